// File: rtl/timer_pkg.sv
// Shared encodings and helpers for the two-digit BCD up/down timer.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   localparam logic [3:0] BCD_NINE    = 4'd9;
   localparam logic [7:0] MAX_VAL_DEF = 8'h59;

   function automatic logic bcd_valid(input logic [7:0] v);
      return (v[7:4] <= BCD_NINE) && (v[3:0] <= BCD_NINE);
   endfunction

endpackage

// File: rtl/sw_sync.sv
// Single-bit level synchroniser into the slow CLK_temp domain.
module sw_sync #(
   parameter int STAGES = 2
) (
   input  logic CLK_temp,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge CLK_temp or negedge rst_n) begin
      if (!rst_n) ff <= '0;
      else        ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/bcd_updown_timer.sv
// Two-digit BCD up/down counter with IDLE/RUN/PAUSE control, clear and preset load.
module bcd_updown_timer
   import timer_pkg::*;
#(
   parameter logic [7:0] MAX_VAL     = MAX_VAL_DEF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       CLK_temp,
   input  logic       rst_n,
   input  logic       en_sw,
   input  logic       dir_sw,
   input  logic       clr_sw,
   input  logic       load_sw,
   input  logic [7:0] load_val,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       wrap,
   output logic       err,
   output logic [1:0] state
);

   logic en_s, dir_s, clr_s, load_s;

   sw_sync #(.STAGES(SYNC_STAGES)) u_sync_en (
      .CLK_temp(CLK_temp), .rst_n(rst_n), .d(en_sw),   .q(en_s));
   sw_sync #(.STAGES(SYNC_STAGES)) u_sync_dir (
      .CLK_temp(CLK_temp), .rst_n(rst_n), .d(dir_sw),  .q(dir_s));
   sw_sync #(.STAGES(SYNC_STAGES)) u_sync_clr (
      .CLK_temp(CLK_temp), .rst_n(rst_n), .d(clr_sw),  .q(clr_s));
   sw_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
      .CLK_temp(CLK_temp), .rst_n(rst_n), .d(load_sw), .q(load_s));

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       wrap_q, wrap_d;
   logic       err_q, err_d;

   logic [7:0] up_val, dn_val;
   logic       up_wrap, dn_wrap;
   logic       load_ok, load_hit;

   // Next value in each direction; count never exceeds MAX_VAL so the
   // terminal checks are plain equality.
   always_comb begin
      up_wrap = (cnt_q == MAX_VAL);
      if (up_wrap)                    up_val = 8'h00;
      else if (cnt_q[3:0] == BCD_NINE) up_val = {cnt_q[7:4] + 4'd1, 4'd0};
      else                            up_val = {cnt_q[7:4], cnt_q[3:0] + 4'd1};

      dn_wrap = (cnt_q == 8'h00);
      if (dn_wrap)                 dn_val = MAX_VAL;
      else if (cnt_q[3:0] == 4'd0) dn_val = {cnt_q[7:4] - 4'd1, BCD_NINE};
      else                         dn_val = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
   end

   assign load_ok  = bcd_valid(load_val) && (load_val <= MAX_VAL);
   assign load_hit = load_s && ((state_q == IDLE) || (state_q == PAUSE));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      err_d   = err_q;
      if (clr_s) begin
         state_d = IDLE;
         cnt_d   = 8'h00;
         err_d   = 1'b0;
      end else if (load_hit) begin
         if (load_ok) cnt_d = load_val;
         else         err_d = 1'b1;
      end else begin
         case (state_q)
            IDLE:  if (en_s) state_d = RUN;
            PAUSE: if (en_s) state_d = RUN;
            RUN: begin
               if (!en_s) begin
                  state_d = PAUSE;
               end else if (dir_s) begin
                  cnt_d  = up_val;
                  wrap_d = up_wrap;
               end else begin
                  cnt_d  = dn_val;
                  wrap_d = dn_wrap;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 8'h00;
            end
         endcase
      end
   end

   always_ff @(posedge CLK_temp or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'h00;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
      end
   end

   assign tens  = cnt_q[7:4];
   assign ones  = cnt_q[3:0];
   assign wrap  = wrap_q;
   assign err   = err_q;
   assign state = state_q;

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Directed bench for bcd_updown_timer: vector table plus looped count sequences.
module tb_bcd_updown_timer;
   import timer_pkg::*;

   logic       CLK_temp = 1'b0;
   logic       rst_n    = 1'b0;
   logic       en_sw    = 1'b0;
   logic       dir_sw   = 1'b0;
   logic       clr_sw   = 1'b0;
   logic       load_sw  = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [3:0] tens, ones;
   logic       wrap, err;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;

   bcd_updown_timer #(.MAX_VAL(8'h59), .SYNC_STAGES(2)) dut (
      .CLK_temp(CLK_temp), .rst_n(rst_n), .en_sw(en_sw), .dir_sw(dir_sw),
      .clr_sw(clr_sw), .load_sw(load_sw), .load_val(load_val),
      .tens(tens), .ones(ones), .wrap(wrap), .err(err), .state(state));

   always #5 CLK_temp = ~CLK_temp;

   typedef struct {
      logic       en, dir, clr, ld;
      logic [7:0] lv;
      int         ticks;
      logic [7:0] cnt;
      logic [1:0] st;
      logic       wr, er;
   } vec_t;

   vec_t tbl[$];
   int   row_id = 0;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK_temp);
         @(negedge CLK_temp);
      end
   endtask

   task automatic check(input string name, input logic [7:0] cnt, input logic [1:0] st,
                        input logic wr, input logic er);
      checks++;
      if ({tens, ones} !== cnt || state !== st || wrap !== wr || err !== er) begin
         errors++;
         $display("FAIL %s: got cnt=%h st=%b wrap=%b err=%b, want cnt=%h st=%b wrap=%b err=%b",
                  name, {tens, ones}, state, wrap, err, cnt, st, wr, er);
      end
   endtask

   task automatic row(input logic en, input logic dir, input logic clr, input logic ld,
                      input logic [7:0] lv, input int ticks, input logic [7:0] cnt,
                      input logic [1:0] st, input logic wr, input logic er);
      vec_t v;
      v.en = en; v.dir = dir; v.clr = clr; v.ld = ld; v.lv = lv; v.ticks = ticks;
      v.cnt = cnt; v.st = st; v.wr = wr; v.er = er;
      tbl.push_back(v);
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) begin
         en_sw = tbl[i].en; dir_sw = tbl[i].dir; clr_sw = tbl[i].clr;
         load_sw = tbl[i].ld; load_val = tbl[i].lv;
         tick(tbl[i].ticks);
         check($sformatf("row%0d", row_id), tbl[i].cnt, tbl[i].st, tbl[i].wr, tbl[i].er);
         row_id++;
      end
      tbl.delete();
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   initial begin
      int v;
      #1 check("reset_init", 8'h00, IDLE, 1'b0, 1'b0);
      @(negedge CLK_temp);
      rst_n = 1'b1;

      // idle with en low, then start: RUN on the third edge, no count on it
      row(0,0,0,0,8'h00, 5, 8'h00, IDLE, 0,0);
      row(1,1,0,0,8'h00, 2, 8'h00, IDLE, 0,0);
      row(1,1,0,0,8'h00, 1, 8'h00, RUN,  0,0);
      run_tbl();

      for (int k = 1; k <= 61; k++) begin
         tick(1);
         check($sformatf("up%0d", k), to_bcd(k % 60), RUN, k == 60, 1'b0);
      end
      tick(36);
      check("up_at37", 8'h37, RUN, 1'b0, 1'b0);

      // asynchronous reset mid-count
      rst_n = 1'b0; en_sw = 1'b0; dir_sw = 1'b0;
      #1 check("reset_mid", 8'h00, IDLE, 1'b0, 1'b0);
      @(negedge CLK_temp);
      rst_n = 1'b1;

      row(0,0,0,0,8'h00, 3, 8'h00, IDLE, 0,0);
      row(0,0,0,1,8'h03, 2, 8'h00, IDLE, 0,0);
      row(0,0,0,1,8'h03, 1, 8'h03, IDLE, 0,0);
      row(1,0,0,0,8'h03, 2, 8'h03, IDLE, 0,0);
      row(1,0,0,0,8'h03, 1, 8'h03, RUN,  0,0);
      row(1,0,0,0,8'h03, 1, 8'h02, RUN,  0,0);
      row(1,0,0,0,8'h03, 1, 8'h01, RUN,  0,0);
      row(1,0,0,0,8'h03, 1, 8'h00, RUN,  0,0);
      row(1,0,0,0,8'h03, 1, 8'h59, RUN,  1,0);
      row(1,0,0,0,8'h03, 1, 8'h58, RUN,  0,0);
      run_tbl();

      for (v = 57; v >= 26; v--) begin
         tick(1);
         check($sformatf("dn%0d", v), to_bcd(v), RUN, 1'b0, 1'b0);
      end

      // pause, resume upward, reverse direction, pause again
      row(0,0,0,0,8'h03, 1, 8'h25, RUN,   0,0);
      row(0,0,0,0,8'h03, 1, 8'h24, RUN,   0,0);
      row(0,0,0,0,8'h03, 1, 8'h24, PAUSE, 0,0);
      row(0,0,0,0,8'h03, 5, 8'h24, PAUSE, 0,0);
      row(1,1,0,0,8'h03, 2, 8'h24, PAUSE, 0,0);
      row(1,1,0,0,8'h03, 1, 8'h24, RUN,   0,0);
      row(1,1,0,0,8'h03, 1, 8'h25, RUN,   0,0);
      row(1,0,0,0,8'h03, 1, 8'h26, RUN,   0,0);
      row(1,0,0,0,8'h03, 1, 8'h27, RUN,   0,0);
      row(1,0,0,0,8'h03, 1, 8'h26, RUN,   0,0);
      row(1,0,0,0,8'h03, 1, 8'h25, RUN,   0,0);
      row(0,0,0,0,8'h03, 1, 8'h24, RUN,   0,0);
      row(0,0,0,0,8'h03, 1, 8'h23, RUN,   0,0);
      row(0,0,0,0,8'h03, 1, 8'h23, PAUSE, 0,0);
      // invalid and out-of-range loads, sticky err, clear
      row(0,0,0,1,8'h6A, 2, 8'h23, PAUSE, 0,0);
      row(0,0,0,1,8'h6A, 1, 8'h23, PAUSE, 0,1);
      row(0,0,0,0,8'h6A, 3, 8'h23, PAUSE, 0,1);
      row(0,0,0,1,8'h59, 2, 8'h23, PAUSE, 0,1);
      row(0,0,0,1,8'h59, 1, 8'h59, PAUSE, 0,1);
      row(0,0,1,0,8'h59, 2, 8'h59, PAUSE, 0,1);
      row(0,0,1,0,8'h59, 1, 8'h00, IDLE,  0,0);
      row(0,0,0,1,8'h61, 2, 8'h00, IDLE,  0,0);
      row(0,0,0,1,8'h61, 1, 8'h00, IDLE,  0,1);
      row(0,0,1,0,8'h61, 2, 8'h00, IDLE,  0,1);
      row(0,0,1,0,8'h61, 1, 8'h00, IDLE,  0,0);
      // clear beats load and count; held load reloads after clear drops
      row(0,0,0,1,8'h38, 2, 8'h00, IDLE,  0,0);
      row(0,0,0,1,8'h38, 1, 8'h38, IDLE,  0,0);
      row(1,1,0,0,8'h38, 2, 8'h38, IDLE,  0,0);
      row(1,1,0,0,8'h38, 1, 8'h38, RUN,   0,0);
      row(1,1,1,1,8'h12, 1, 8'h39, RUN,   0,0);
      row(1,1,1,1,8'h12, 1, 8'h40, RUN,   0,0);
      row(1,1,1,1,8'h12, 1, 8'h00, IDLE,  0,0);
      row(1,1,1,1,8'h12, 2, 8'h00, IDLE,  0,0);
      row(1,1,0,1,8'h12, 2, 8'h00, IDLE,  0,0);
      row(1,1,0,1,8'h12, 1, 8'h12, IDLE,  0,0);
      row(1,1,0,0,8'h12, 2, 8'h12, IDLE,  0,0);
      row(1,1,0,0,8'h12, 1, 8'h12, RUN,   0,0);
      row(1,1,0,0,8'h12, 1, 8'h13, RUN,   0,0);
      run_tbl();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
